// File: rtl/cmp_arbiter_pkg.sv
// Shared types for the EX-stage compare arbiter: RV32I word, branch funct3 and FSM state.
package cmp_arbiter_pkg;

    localparam int unsigned RV32I_WORD_W   = 32;
    localparam int unsigned CMP_ARB_MAX_REQ = 4;

    typedef logic [RV32I_WORD_W-1:0] rv32i_word;

    // Encodings 3'b010 and 3'b011 are illegal; they still flow through as a 0 result.
    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } cmp_arb_state_t;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between the compare requesters and the shared arbiter.
interface cmp_arbiter_if
    import cmp_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
);

    logic           [NUM_REQ-1:0] req_valid;
    logic           [NUM_REQ-1:0] req_ready;
    branch_funct3_t [NUM_REQ-1:0] req_cmpop;
    rv32i_word      [NUM_REQ-1:0] req_a;
    rv32i_word      [NUM_REQ-1:0] req_b;
    logic           [NUM_REQ-1:0] rsp_valid;
    logic                         rsp_o;
    logic           [NUM_REQ-1:0] rsp_ready;

    // Requester side.
    modport master (
        output req_valid,
        output req_cmpop,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_o
    );

    // Arbiter side.
    modport slave (
        input  req_valid,
        input  req_cmpop,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_o
    );

endinterface

// File: rtl/cmp_arbiter_cmp.sv
// Branch/compare unit: evaluates one RV32I branch condition on two words.
module cmp
    import cmp_arbiter_pkg::*;
(
    input  branch_funct3_t cmpop,
    input  rv32i_word      a,
    input  rv32i_word      b,
    output logic           br_en
);

    // Decode the compare op; unknown encodings resolve to 0.
    always_comb begin
        br_en = 1'b0;
        case (cmpop)
            beq:     br_en = (a == b);
            bne:     br_en = (a != b);
            blt:     br_en = ($signed(a) <  $signed(b));
            bge:     br_en = ($signed(a) >= $signed(b));
            bltu:    br_en = (a <  b);
            bgeu:    br_en = (a >= b);
            default: br_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin sharing of one compare unit between NUM_REQ requesters,
// with a single registered result slot that can drain and refill in one cycle.
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
    input logic          clk,
    input logic          rst,
    cmp_arbiter_if.slave bus
);

    cmp_arb_state_t state_q;
    cmp_arb_state_t state_d;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] owner_d;
    logic [IDW-1:0] rr_q;
    logic [IDW-1:0] rr_d;
    logic           res_q;
    logic           res_d;

    logic           grant_vld;
    logic [IDW-1:0] grant_idx;
    logic           grant_en;
    logic [IDW-1:0] sel_idx;
    branch_funct3_t sel_op;
    rv32i_word      sel_a;
    rv32i_word      sel_b;
    logic           cmp_o;

    // Round-robin pick: first valid requester at or after rr_q, wrapping.
    always_comb begin
        int unsigned    cand;
        logic [IDW-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            idx = IDW'(cand);
            if (!grant_vld && bus.req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Steer the granted requester's operands into the comparator (requester 0 when idle).
    always_comb begin
        sel_idx = grant_vld ? grant_idx : '0;
        sel_op  = bus.req_cmpop[sel_idx];
        sel_a   = bus.req_a[sel_idx];
        sel_b   = bus.req_b[sel_idx];
    end

    cmp u_cmp (
        .cmpop (sel_op),
        .a     (sel_a),
        .b     (sel_b),
        .br_en (cmp_o)
    );

    // Next-state and handshake outputs; reset masks every output for that cycle.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        res_d         = res_q;
        grant_en      = 1'b0;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_o     = 1'b0;

        if (!rst) begin
            case (state_q)
                EMPTY: begin
                    grant_en = 1'b1;
                end
                FULL: begin
                    bus.rsp_valid[owner_q] = 1'b1;
                    bus.rsp_o              = res_q;
                    grant_en               = bus.rsp_ready[owner_q];
                    if (bus.rsp_ready[owner_q] && !grant_vld) begin
                        state_d = EMPTY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase

            if (grant_en && grant_vld) begin
                bus.req_ready[grant_idx] = 1'b1;
                state_d                  = FULL;
                owner_d                  = grant_idx;
                res_d                    = cmp_o;
                rr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
            end
        end
    end

    // State, owner, pointer and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            owner_q <= '0;
            rr_q    <= '0;
            res_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            res_q   <= res_d;
        end
    end

    a_num_req_range : assert property (@(posedge clk)
        (NUM_REQ >= 2) && (NUM_REQ <= CMP_ARB_MAX_REQ));

    a_req_ready_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.req_ready));

    a_rsp_valid_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.rsp_valid));

    a_no_grant_when_stalled : assert property (@(posedge clk) disable iff (rst)
        (state_q == FULL && !bus.rsp_ready[owner_q]) |-> (bus.req_ready == '0));

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed scenarios plus randomized traffic, checked against a transaction-level model.
module tb_cmp_arbiter;
    import cmp_arbiter_pkg::*;

    localparam int unsigned NREQ = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cmp_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    cmp_arbiter #(.NUM_REQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: at most one outstanding result, tracked as {owner, value}.
    bit              m_pend;
    int              m_own;
    bit              m_res;
    int              m_ptr;
    int              m_gnt;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_rv;
    logic            exp_o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Branch condition from plain integer arithmetic.
    function automatic bit ref_cmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = a[31] ? ua - 64'sd4294967296 : ua;
        sb = b[31] ? ub - 64'sd4294967296 : ub;
        case (op)
            3'd0:    return ua == ub;
            3'd1:    return ua != ub;
            3'd4:    return sa <  sb;
            3'd5:    return sa >= sb;
            3'd6:    return ua <  ub;
            3'd7:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_req(input int i, input bit v, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[i] = v;
        bus.req_cmpop[i] = branch_funct3_t'(op);
        bus.req_a[i]     = a;
        bus.req_b[i]     = b;
    endtask

    // Evaluate the model for the current inputs and compare the DUT outputs.
    task automatic settle();
        #1;
        exp_ready = '0;
        exp_rv    = '0;
        exp_o     = 1'b0;
        m_gnt     = -1;
        if (!rst) begin
            if (m_pend) begin
                exp_rv[m_own] = 1'b1;
                exp_o         = m_res;
            end
            if (!m_pend || bus.rsp_ready[m_own]) begin
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (m_gnt < 0 && bus.req_valid[i]) m_gnt = i;
                end
            end
            if (m_gnt >= 0) exp_ready[m_gnt] = 1'b1;
        end
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        if (rst || exp_rv != '0) check("rsp_o", 32'(bus.rsp_o), 32'(exp_o));
    endtask

    // Advance one clock and update the model with what transferred.
    task automatic edge_step();
        @(posedge clk);
        if (rst) begin
            m_pend = 1'b0;
            m_ptr  = 0;
            m_own  = 0;
            m_res  = 1'b0;
        end else if (m_gnt >= 0) begin
            m_pend = 1'b1;
            m_own  = m_gnt;
            m_res  = ref_cmp(bus.req_cmpop[m_gnt], bus.req_a[m_gnt], bus.req_b[m_gnt]);
            m_ptr  = (m_gnt + 1) % NREQ;
        end else if (m_pend && bus.rsp_ready[m_own]) begin
            m_pend = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        edge_step();
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [NREQ-1:0] acc;
        logic [31:0]     ra;
        logic [31:0]     rb;

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 3'd0, 32'd0, 32'd0);
        m_pend = 1'b0;
        m_own  = 0;
        m_res  = 1'b0;
        m_ptr  = 0;
        m_gnt  = -1;
        @(negedge clk);

        // Reset state.
        settle();
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_o",     32'(bus.rsp_o),     32'd0);
        edge_step();
        cycle();
        rst           = 1'b0;
        bus.rsp_ready = '1;

        // Single bltu request.
        set_req(0, 1'b1, 3'b110, 32'h0000_0001, 32'hFFFF_FFFF);
        settle();
        check("single_grant", 32'(bus.req_ready), 32'd1);
        edge_step();
        bus.req_valid = '0;
        settle();
        check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("single_rsp_o",     32'(bus.rsp_o),     32'd1);
        edge_step();

        // Signed compares from requester 1.
        set_req(1, 1'b1, 3'b100, 32'h0000_0001, 32'hFFFF_FFFF);
        cycle();
        set_req(1, 1'b1, 3'b101, 32'h8000_0000, 32'h0000_0000);
        settle();
        check("blt_rsp_valid", 32'(bus.rsp_valid), 32'd2);
        check("blt_rsp_o",     32'(bus.rsp_o),     32'd0);
        edge_step();
        bus.req_valid = '0;
        settle();
        check("bge_rsp_o", 32'(bus.rsp_o), 32'd0);
        edge_step();

        // Contention with immediate consumption: grants alternate.
        set_req(0, 1'b1, 3'b000, 32'd9, 32'd9);
        set_req(1, 1'b1, 3'b001, 32'd9, 32'd9);
        for (int c = 0; c < 4; c++) begin
            settle();
            check("contend_grant", 32'(bus.req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
            if (c > 0) check("contend_owner", 32'(bus.rsp_valid), (c % 2 == 1) ? 32'd1 : 32'd2);
            edge_step();
        end
        bus.req_valid = '0;
        cycle();

        // Backpressure on requester 0's result.
        set_req(0, 1'b1, 3'b000, 32'd5, 32'd5);
        bus.rsp_ready = '0;
        settle();
        check("bp_grant", 32'(bus.req_ready), 32'd1);
        edge_step();
        bus.req_valid[0] = 1'b0;
        set_req(1, 1'b1, 3'b110, 32'd3, 32'd4);
        repeat (3) begin
            settle();
            check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_hold_o",     32'(bus.rsp_o),     32'd1);
            edge_step();
        end
        bus.rsp_ready = 2'b01;
        settle();
        check("bp_release_grant", 32'(bus.req_ready), 32'd2);
        edge_step();
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        cycle();

        // Reset while holding a result for requester 1.
        set_req(1, 1'b1, 3'b111, 32'd5, 32'd3);
        bus.rsp_ready = '0;
        cycle();
        bus.req_valid = '0;
        rst           = 1'b1;
        bus.rsp_ready = 2'b10;
        settle();
        check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        edge_step();
        rst           = 1'b0;
        bus.rsp_ready = '1;
        set_req(0, 1'b1, 3'b000, 32'd1, 32'd2);
        set_req(1, 1'b1, 3'b000, 32'd3, 32'd3);
        settle();
        check("rst_mid_no_rsp",  32'(bus.rsp_valid), 32'd0);
        check("rst_mid_ptr",     32'(bus.req_ready), 32'd1);
        edge_step();
        bus.req_valid = '0;
        cycle();

        // Illegal funct3 still yields a response of 0.
        set_req(0, 1'b1, 3'b010, 32'd7, 32'd7);
        settle();
        check("illegal_grant", 32'(bus.req_ready), 32'd1);
        edge_step();
        bus.req_valid = '0;
        settle();
        check("illegal_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("illegal_rsp_o",     32'(bus.rsp_o),     32'd0);
        edge_step();

        // Randomized traffic with backpressure, drops and occasional reset.
        acc = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && !acc[i]) begin
                    if ($urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    ra = rand_word();
                    rb = ($urandom_range(0, 3) == 0) ? ra : rand_word();
                    set_req(i, 1'b1, 3'($urandom_range(0, 7)), ra, rb);
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
                bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 199) == 0);
            settle();
            acc = exp_ready;
            edge_step();
        end
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one branch/compare unit (a `cmp` instance) between NUM_REQ requesters, for example the branch unit and the SLT/SLTU path.
- Requests use valid/ready handshakes and are arbitrated round-robin.
- Each comparison result is registered and returned on a per-requester response handshake.
- Sits in the EX stage, between the requesters' issue logic and the shared comparator.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- IDW, $clog2(NUM_REQ), width of the internal owner and pointer indices (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  [NUM_REQ]  requester i has a compare pending.
- req_ready  output  [NUM_REQ]  requester i's operands are accepted this cycle.
- req_cmpop  input  [NUM_REQ] x branch_funct3_t  compare operation per requester.
- req_a  input  [NUM_REQ] x rv32i_word  operand A per requester.
- req_b  input  [NUM_REQ] x rv32i_word  operand B per requester.
- rsp_valid  output  [NUM_REQ]  result pending for requester i.
- rsp_o  output  1  shared result bit; meaningful only where rsp_valid is set.
- rsp_ready  input  [NUM_REQ]  requester i consumes its result.

Behaviour:
- Reset: clk, rst as listed. Reset is synchronous, active-high.
  - State = EMPTY, rr_ptr = 0, owner = 0, res = 0.
  - Outputs during and after reset: all req_ready = 0, all rsp_valid = 0, rsp_o = 0.
- Handshakes:
  - A request transfers when req_valid[i] && req_ready[i].
  - A response transfers when rsp_valid[i] && rsp_ready[i].
  - A requester holds req_cmpop/req_a/req_b stable while req_valid is high and ready is low.
- Grant selection (combinational):
  - Scan i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ; grant the first i with req_valid[i].
  - At most one req_ready bit is set per cycle.
  - The comparator is driven by the granted requester's cmpop/a/b.
  - When nothing is granted, drive the comparator with requester 0's inputs; the result is unused.
- State machine, two states:
  - EMPTY:
    - grant_en = 1.
    - On a grant g: res <= cmp_o, owner <= g, rr_ptr <= (g+1) mod NUM_REQ, go to FULL.
    - No valid requester: stay in EMPTY.
  - FULL:
    - rsp_valid[owner] = 1; rsp_o = res.
    - grant_en = rsp_ready[owner]. This is same-cycle turnaround: the register is freed and refilled in one cycle.
    - If rsp_ready[owner] and a grant g is issued: capture the new result, owner <= g, update rr_ptr, stay in FULL.
    - If rsp_ready[owner] and no grant: go to EMPTY.
    - If !rsp_ready[owner]: hold everything, all req_ready = 0.
- Timing:
  - Latency from request transfer to rsp_valid is exactly 1 cycle.
  - Throughput is 1 compare per cycle when responses are consumed immediately.
- Fairness:
  - rr_ptr advances only on a grant.
  - A continuously valid requester waits at most NUM_REQ-1 grants.
- Comparator semantics:
  - beq/bne: equality.
  - blt/bge: signed 32-bit compare.
  - bltu/bgeu: unsigned 32-bit compare.
  - Illegal funct3 (010, 011): result 0, still returns a response.
- Boundary conditions:
  - rsp_ready for a non-owner, or in EMPTY, is ignored.
  - req_valid dropping before grant is legal; the request is simply not taken.
  - Reset in FULL discards the pending result; no response is issued.
- Assertions:
  - onehot0(req_ready).
  - onehot0(rsp_valid).
  - No req_ready while in FULL && !rsp_ready[owner].

Decomposition:
- Reuse the types package (branch_funct3_t, rv32i_word). Add to it:
  - cmp_arb_state_t enum {EMPTY, FULL}.
  - localparam CMP_ARB_MAX_REQ = 4.
- Sub-module: instantiate the existing `cmp` as the single shared datapath. The round-robin pick stays inline in an always_comb loop; no separate arbiter module.

Test Plan:
- Single request: req0 bltu, a=0x0000_0001, b=0xFFFF_FFFF -> req_ready[0] in cycle 0; rsp_valid[0]=1, rsp_o=1 in cycle 1.
- Signed vs unsigned: req1 blt with the same operands -> rsp_o=0. Then bge, a=0x8000_0000, b=0 -> rsp_o=0.
- Contention, both valid every cycle, rsp_ready tied 1, rr_ptr=0:
  - Grants alternate 0,1,0,1 on consecutive cycles.
  - Responses follow one cycle later with the correct owner bit.
- Backpressure:
  - req0 beq 5==5 granted; hold rsp_ready[0]=0 for 3 cycles.
  - During the hold: rsp_valid[0] and rsp_o=1 stay stable, and req_ready stays all 0 despite req1 valid.
  - Release -> req1 granted in the same cycle.
- Reset mid-operation: assert rst while in FULL with owner=1 -> next cycle all rsp_valid=0, rr_ptr=0, and no response is delivered to req1.
- Illegal funct3 3'b010 from req0 -> response delivered with rsp_o=0; arbiter continues normally.
